gcd_job_queue: RTL and testbench

Command-queue front end for the GCD accelerator in the GPIO emulator. Sits between the CPU bus and the GCD engine. The CPU writes operand pairs into a job FIFO; the block issues them one at a time to the engine over a start/done handshake. Results go into a result FIFO that the CPU reads. The CPU no longer has to poll the engine per job.

---
 rtl/gcd_job_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_gcd_job_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_queue.sv
// gcd_job_queue: CPU command-queue front end for the GCD engine.
// The CPU stages operand A, pushes {A,B} pairs into a job FIFO and pops
// results from a result FIFO; a small dispatcher feeds the engine one
// job at a time over a start/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   n_reset     synchronous, active-high reset
//   saddress    CPU bus address (registers at BASE+0/4/8/C)
//   srd, swr    one-cycle read / write strobes
//   sdata_in    write data
//   sdata_out   registered read data, held until the next read
//   eng_start   one-cycle job launch pulse
//   eng_a/b     operands of the job in flight
//   eng_done    one-cycle completion pulse
//   eng_result  GCD result, valid with eng_done
module gcd_job_queue #(
    parameter int          DEPTH = 4,
    parameter logic [15:0] BASE  = 16'h108
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic        eng_start,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_done,
    input  logic [31:0] eng_result
);

    localparam int          PW  = $clog2(DEPTH);
    localparam logic [3:0]  DEP = 4'(DEPTH);
    localparam logic [15:0] A_OPA = BASE;
    localparam logic [15:0] A_OPB = BASE + 16'h4;
    localparam logic [15:0] A_RES = BASE + 16'h8;
    localparam logic [15:0] A_STA = BASE + 16'hC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e state_q;

    logic [31:0]   opa_q, opa_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          start_q;
    logic [31:0]   eng_a_q, eng_b_q;

    logic [31:0]   job_a_q [DEPTH];
    logic [31:0]   job_b_q [DEPTH];
    logic [31:0]   res_q   [DEPTH];

    logic [PW-1:0] job_wp_q, job_wp_d, job_rp_q, job_rp_d;
    logic [PW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [3:0]    job_cnt_q, job_cnt_d, res_cnt_q, res_cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, zer_q, zer_d;

    logic sel_opa, sel_opb, sel_res, sel_sta;
    logic wr_opa, wr_opb, wr_sta, rd_res;
    logic push_zero, job_full_eff, job_push, job_ovf, job_pop;
    logic res_push, res_pop, res_unf;
    logic inflight;
    logic [31:0] status;

    assign sel_opa = (saddress == A_OPA);
    assign sel_opb = (saddress == A_OPB);
    assign sel_res = (saddress == A_RES);
    assign sel_sta = (saddress == A_STA);

    assign wr_opa = swr && sel_opa;
    assign wr_opb = swr && sel_opb;
    assign wr_sta = swr && sel_sta;
    assign rd_res = srd && sel_res;

    // Launch only when a result slot is guaranteed free for the job.
    assign job_pop = (state_q == S_IDLE) && (job_cnt_q != 4'd0)
                     && (res_cnt_q < DEP);

    // A zero operand would never terminate in the engine.
    assign push_zero    = wr_opb && ((opa_q == 32'd0) || (sdata_in == 32'd0));
    // Full is judged after a same-cycle dispatcher pop.
    assign job_full_eff = (job_cnt_q == DEP) && !job_pop;
    assign job_push     = wr_opb && !push_zero && !job_full_eff;
    assign job_ovf      = wr_opb && !push_zero && job_full_eff;

    assign res_push = (state_q == S_WAIT) && eng_done;
    assign res_pop  = rd_res && (res_cnt_q != 4'd0);
    assign res_unf  = rd_res && (res_cnt_q == 4'd0);

    assign inflight = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign status = {13'd0, zer_q, unf_q, ovf_q,
                     res_cnt_q, job_cnt_q,
                     3'd0, inflight,
                     (res_cnt_q == 4'd0), (res_cnt_q == DEP),
                     (job_cnt_q == 4'd0), (job_cnt_q == DEP)};

    always_comb begin
        opa_d     = opa_q;
        job_wp_d  = job_wp_q;
        job_rp_d  = job_rp_q;
        job_cnt_d = job_cnt_q + {3'd0, job_push} - {3'd0, job_pop};
        res_wp_d  = res_wp_q;
        res_rp_d  = res_rp_q;
        res_cnt_d = res_cnt_q + {3'd0, res_push} - {3'd0, res_pop};
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        zer_d     = zer_q;
        rdata_d   = rdata_q;

        if (wr_opa)
            opa_d = sdata_in;
        if (job_push)
            job_wp_d = job_wp_q + PW'(1);
        if (job_pop)
            job_rp_d = job_rp_q + PW'(1);
        if (res_push)
            res_wp_d = res_wp_q + PW'(1);
        if (res_pop)
            res_rp_d = res_rp_q + PW'(1);

        // W1C first so a same-cycle event still sets the bit.
        if (wr_sta) begin
            if (sdata_in[16]) ovf_d = 1'b0;
            if (sdata_in[17]) unf_d = 1'b0;
            if (sdata_in[18]) zer_d = 1'b0;
        end
        if (job_ovf)   ovf_d = 1'b1;
        if (res_unf)   unf_d = 1'b1;
        if (push_zero) zer_d = 1'b1;

        if (srd) begin
            unique case (1'b1)
                sel_opa: rdata_d = opa_q;
                sel_sta: rdata_d = status;
                sel_res: rdata_d = res_pop ? res_q[res_rp_q] : 32'd0;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            opa_q     <= 32'd0;
            rdata_q   <= 32'd0;
            job_wp_q  <= '0;
            job_rp_q  <= '0;
            job_cnt_q <= 4'd0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= 4'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            zer_q     <= 1'b0;
        end else begin
            opa_q     <= opa_d;
            rdata_q   <= rdata_d;
            job_wp_q  <= job_wp_d;
            job_rp_q  <= job_rp_d;
            job_cnt_q <= job_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            zer_q     <= zer_d;
        end
    end

    // FIFO storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (job_push) begin
            job_a_q[job_wp_q] <= opa_q;
            job_b_q[job_wp_q] <= sdata_in;
        end
        if (res_push)
            res_q[res_wp_q] <= eng_result;
    end

    // Dispatcher: operands are loaded on the edge entering ISSUE so
    // they are valid in the same cycle as the start pulse.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            eng_a_q <= 32'd0;
            eng_b_q <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (job_pop) begin
                        state_q <= S_ISSUE;
                        start_q <= 1'b1;
                        eng_a_q <= job_a_q[job_rp_q];
                        eng_b_q <= job_b_q[job_rp_q];
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    start_q <= 1'b0;
                end
                S_WAIT: begin
                    if (eng_done)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign sdata_out = rdata_q;
    assign eng_start = start_q;
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;

endmodule

// File: tb/tb_gcd_job_queue.sv
// tb_gcd_job_queue: directed bench for gcd_job_queue.
// All stimulus and sampling happen on the falling clock edge.
module tb_gcd_job_queue;

    localparam logic [15:0] A_OPA = 16'h108;
    localparam logic [15:0] A_OPB = 16'h10C;
    localparam logic [15:0] A_RES = 16'h110;
    localparam logic [15:0] A_STA = 16'h114;

    logic        clk;
    logic        n_reset;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic        eng_start;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        eng_done;
    logic [31:0] eng_result;

    gcd_job_queue #(
        .DEPTH(4),
        .BASE (16'h108)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_in  (sdata_in),
        .sdata_out (sdata_out),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_result(eng_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] g;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    int tests = 0;
    int fails = 0;
    int start_cnt;
    bit eng_auto;
    bit eng_busy;
    int eng_lat;
    int eng_cnt;
    logic [31:0] a_lat, b_lat;
    logic [31:0] rv;

    function automatic logic [31:0] gcd_f(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 32'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle; also runs the engine model.
    task automatic step();
        @(negedge clk);
        eng_done = 1'b0;
        if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = gcd_f(a_lat, b_lat);
                eng_busy   = 1'b0;
            end
        end
        if (eng_start) begin
            start_cnt++;
            if (eng_auto) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_lat;
                a_lat    = eng_a;
                b_lat    = eng_b;
            end
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        saddress = addr;
        sdata_in = data;
        swr      = 1'b1;
        step();
        swr      = 1'b0;
        sdata_in = 32'd0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [31:0] data);
        saddress = addr;
        srd      = 1'b1;
        step();
        srd      = 1'b0;
        data     = sdata_out;
    endtask

    task automatic reset_dut();
        n_reset   = 1'b1;
        eng_busy  = 1'b0;
        step();
        step();
        n_reset   = 1'b0;
        start_cnt = 0;
    endtask

    task automatic wait_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (eng_start) seen = 1'b1;
            else step();
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (eng_done) seen = 1'b1;
            else step();
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        bit seen;
        n_reset    = 1'b1;
        saddress   = 16'd0;
        srd        = 1'b0;
        swr        = 1'b0;
        sdata_in   = 32'd0;
        eng_done   = 1'b0;
        eng_result = 32'd0;
        eng_auto   = 1'b1;
        eng_busy   = 1'b0;
        eng_lat    = 10;
        eng_cnt    = 0;
        start_cnt  = 0;
        a_lat      = 32'd0;
        b_lat      = 32'd0;

        vecs[0] = '{32'd48, 32'd18, 32'd6, 10};
        vecs[1] = '{32'd7, 32'd21, 32'd7, 3};
        vecs[2] = '{32'd100, 32'd75, 32'd25, 1};
        vecs[3] = '{32'd17, 32'd5, 32'd1, 4};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 2};
        vecs[5] = '{32'd12, 32'd12, 32'd12, 6};

        // Reset state
        reset_dut();
        chk("rst sdata_out", sdata_out, 32'd0);
        chk("rst eng_start", {31'd0, eng_start}, 32'd0);
        chk("rst eng_a", eng_a, 32'd0);
        chk("rst eng_b", eng_b, 32'd0);
        rd(A_STA, rv);
        chk("rst status", rv, 32'h0000_000A);
        rd(A_OPA, rv);
        chk("rst opa", rv, 32'd0);

        // Single jobs from the table
        for (int i = 0; i < 6; i++) begin
            eng_lat = vecs[i].lat;
            wr(A_OPA, vecs[i].a);
            wr(A_OPB, vecs[i].b);
            chk($sformatf("v%0d start N+1", i), {31'd0, eng_start}, 32'd0);
            step();
            chk($sformatf("v%0d start N+2", i), {31'd0, eng_start}, 32'd1);
            chk($sformatf("v%0d eng_a", i), eng_a, vecs[i].a);
            chk($sformatf("v%0d eng_b", i), eng_b, vecs[i].b);
            wait_done($sformatf("v%0d done", i));
            rd(A_STA, rv);
            chk($sformatf("v%0d st@M", i), rv & 32'h0000_F010, 32'h0000_0010);
            rd(A_STA, rv);
            chk($sformatf("v%0d st@M+1", i), rv & 32'h0000_F010, 32'h0000_1000);
            rd(A_RES, rv);
            chk($sformatf("v%0d result", i), rv, vecs[i].g);
            rd(A_STA, rv);
            chk($sformatf("v%0d st end", i), rv, 32'h0000_000A);
        end
        rd(A_OPB, rv);
        chk("opb read", rv, 32'd0);
        rd(16'h0200, rv);
        chk("unmapped read", rv, 32'd0);

        // Job overflow with a stuck engine, then W1C
        reset_dut();
        eng_auto = 1'b0;
        wr(A_OPA, 32'd7);
        for (int k = 0; k < 6; k++) wr(A_OPB, 32'd21);
        chk("ovf starts", start_cnt, 32'd1);
        chk("ovf eng_a", eng_a, 32'd7);
        chk("ovf eng_b", eng_b, 32'd21);
        rd(A_STA, rv);
        chk("ovf status", rv, 32'h0001_0419);
        wr(A_OPB, 32'd0);
        rd(A_RES, rv);
        chk("ovf unf read", rv, 32'd0);
        rd(A_STA, rv);
        chk("ovf sticky all", rv, 32'h0007_0419);
        wr(A_STA, 32'h0001_0000);
        rd(A_STA, rv);
        chk("w1c ovf only", rv, 32'h0006_0419);
        wr(A_STA, 32'h0006_0000);
        rd(A_STA, rv);
        chk("w1c rest", rv, 32'h0000_0419);

        // Zero rejection
        reset_dut();
        eng_auto = 1'b1;
        eng_lat  = 3;
        wr(A_OPA, 32'd0);
        wr(A_OPB, 32'd5);
        for (int k = 0; k < 4; k++) step();
        rd(A_STA, rv);
        chk("zero a status", rv, 32'h0004_000A);
        wr(A_STA, 32'h0004_0000);
        wr(A_OPA, 32'd9);
        wr(A_OPB, 32'd0);
        for (int k = 0; k < 4; k++) step();
        rd(A_STA, rv);
        chk("zero b status", rv, 32'h0004_000A);
        chk("zero starts", start_cnt, 32'd0);

        // Result backpressure
        reset_dut();
        eng_auto = 1'b1;
        eng_lat  = 2;
        wr(A_OPA, 32'd6);  wr(A_OPB, 32'd4);
        wr(A_OPA, 32'd9);  wr(A_OPB, 32'd6);
        wr(A_OPA, 32'd10); wr(A_OPB, 32'd5);
        wr(A_OPA, 32'd14); wr(A_OPB, 32'd21);
        wr(A_OPA, 32'd8);  wr(A_OPB, 32'd12);
        for (int k = 0; k < 60; k++) step();
        rd(A_STA, rv);
        chk("bp status", rv, 32'h0000_4104);
        chk("bp starts", start_cnt, 32'd4);
        rd(A_RES, rv);
        chk("bp res0", rv, 32'd2);
        seen = eng_start;
        if (!seen) begin
            step();
            seen = eng_start;
        end
        chk("bp restart", {31'd0, seen}, 32'd1);
        wait_done("bp done5");
        step();
        rd(A_RES, rv);
        chk("bp res1", rv, 32'd3);
        rd(A_RES, rv);
        chk("bp res2", rv, 32'd5);
        rd(A_RES, rv);
        chk("bp res3", rv, 32'd7);
        rd(A_RES, rv);
        chk("bp res4", rv, 32'd4);
        rd(A_STA, rv);
        chk("bp drained", rv, 32'h0000_000A);

        // Underflow and done/pop in the same cycle
        reset_dut();
        eng_auto = 1'b0;
        rd(A_RES, rv);
        chk("unf data", rv, 32'd0);
        rd(A_STA, rv);
        chk("unf status", rv, 32'h0002_000A);
        wr(A_STA, 32'h0002_0000);
        wr(A_OPA, 32'd6);
        wr(A_OPB, 32'd4);
        wait_start("sim start1");
        step();
        eng_done   = 1'b1;
        eng_result = 32'h0000_AAAA;
        step();
        step();
        wr(A_OPA, 32'd9);
        wr(A_OPB, 32'd6);
        wait_start("sim start2");
        step();
        eng_done   = 1'b1;
        eng_result = 32'h0000_BBBB;
        saddress   = A_RES;
        srd        = 1'b1;
        step();
        srd = 1'b0;
        chk("sim pop data", sdata_out, 32'h0000_AAAA);
        rd(A_STA, rv);
        chk("sim status", rv, 32'h0000_1002);
        rd(A_RES, rv);
        chk("sim order", rv, 32'h0000_BBBB);
        eng_done   = 1'b1;
        eng_result = 32'h0000_CCCC;
        step();
        step();
        rd(A_STA, rv);
        chk("idle done ignored", rv, 32'h0000_000A);

        // Reset while waiting on the engine
        reset_dut();
        eng_auto = 1'b0;
        wr(A_OPA, 32'd40);
        wr(A_OPB, 32'd16);
        wait_start("rw start");
        step();
        step();
        rd(A_OPA, rv);
        chk("rw opa", rv, 32'd40);
        n_reset = 1'b1;
        step();
        n_reset    = 1'b0;
        eng_done   = 1'b1;
        eng_result = 32'd8;
        step();
        step();
        chk("rw sdata_out", sdata_out, 32'd0);
        chk("rw eng_a", eng_a, 32'd0);
        chk("rw eng_b", eng_b, 32'd0);
        rd(A_STA, rv);
        chk("rw status", rv, 32'h0000_000A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
